conv_index_gen: RTL and testbench
=================================

# conv_index_gen

Loop-index sequencer directly upstream of the convolution address stage. It sweeps the five-deep loop nest (k, h, w, r, s) over runtime bounds. Each step it issues three consecutive index tuples on lanes A, B and C, pulses o_start, and waits for the address stage's finish before advancing. The address stage uses these tuples to form its A/B/C products and its equality code.

## Interface
- H_LEN, default 3: width of h index/limit
- W_LEN, default 3: width of w index/limit
- R_LEN, default 3: width of r index/limit
- S_LEN, default 3: width of s index/limit
- K_LEN, default 3: width of k index/limit
- IDX_W, derived: H_LEN+W_LEN+R_LEN+S_LEN+K_LEN (15 at defaults)
- CNT_W, default 15: width of remaining-iteration counter; must hold the product of all limits

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_go  in  1  start sweep; sampled in IDLE only
- i_h_lim / i_w_lim / i_r_lim / i_s_lim / i_k_lim  in  *_LEN each  loop trip counts; latched on accepted i_go
- o_start  out  1  one-cycle request to address stage
- i_finish  in  1  address stage completion; honoured in WAIT only
- o_idxA / o_idxB / o_idxC  out  IDX_W each  packed {h,w,r,s,k}, h in MSBs
- o_lane_vld  out  3  bit0=A, bit1=B, bit2=C
- o_busy  out  1  high in ISSUE and WAIT
- o_done  out  1  one-cycle pulse at sweep end

## Operation
- Loop order: k outermost, then h, w, r, s innermost. The s index increments first. Each index wraps to 0 at (lim-1) and carries into the next outer index.
- Cursor registers hold (h,w,r,s,k) for lane A. Lane B is cursor+1 and lane C is cursor+2, computed by odometer increment. Wrap inside a group carries normally.
- rem register = iterations not yet issued. Loaded with the product of the limits on i_go.
- o_lane_vld = 111 if rem>=3, 011 if rem==2, 001 if rem==1. Index outputs of invalid lanes are driven to 0.
- States:
  - IDLE: o_start=0, o_busy=0. On i_go: latch limits, zero cursor, load rem. Next state is ISSUE, or DONE if any limit is 0.
  - ISSUE: o_start=1 for exactly this cycle. Next state is WAIT unconditionally.
  - WAIT: hold all index and valid outputs. On i_finish: rem -= min(3,rem) and cursor += 3. Next state is ISSUE if the new rem>0, else DONE.
  - DONE: o_done=1. Next state is IDLE.
- i_go is ignored outside IDLE. i_finish is ignored outside WAIT, including a finish arriving in the same cycle as o_start.
- All outputs are registered or derived only from registers; there is no input-to-output combinational path.
- Reset values: state IDLE, cursor 0, rem 0, o_start 0, o_busy 0, o_done 0, o_lane_vld 000, o_idxA/B/C 0.
- Reset asserted mid-sweep aborts immediately to the reset values. No o_done is produced for the aborted sweep.

## Timing
- i_go high at edge t in IDLE: o_start and o_busy are high during cycle t+1, and the indices are valid in that same cycle.
- The address stage asserts finish the cycle after start, so the steady-state group period is 2 cycles: ISSUE, then WAIT with finish.
- A longer finish latency holds WAIT with outputs stable. o_start never re-asserts during WAIT.
- Last group: finish at edge f gives o_done during f+1 and IDLE at f+2. A new i_go is accepted from f+2.
- Zero-limit go at t: o_done during t+1 and no o_start at all.
- Total issued groups = ceil(N/3), where N is the product of the limits.

## Test plan
- All limits 1, finish one cycle after start:
  - one o_start, lane_vld=001, idxA=0, idxB=idxC=0;
  - o_done two cycles after start.
- s_lim=2, k_lim=2, others 1 (N=4):
  - group 1: vld=111, A={s0,k0}, B={s1,k0}, C={s0,k1};
  - group 2: vld=001, A={s1,k1};
  - then o_done.
- r_lim=0, i_go pulse: o_done next cycle, o_start never asserted, o_busy stays 0.
- All limits 2 with finish delayed 5 cycles each time:
  - exactly 11 o_start pulses;
  - indices constant between start and finish;
  - final vld=011.
- i_go pulsed during WAIT, and i_finish pulsed during ISSUE: both ignored, with sequence and start count unchanged.
- i_rst_n dropped during WAIT of the 2nd group:
  - all outputs 0 asynchronously;
  - after release, a fresh i_go restarts from idx 0.

Source files
------------

// File: rtl/conv_index_gen_if.sv
// conv_index_gen_if
//   Bundles the sweep control inputs and the A/B/C index-tuple bus that the
//   loop-index sequencer hands to the convolution address stage.
//   master : the index generator (conv_index_gen)
//   slave  : the environment (sweep controller + address stage)
//   Signals:
//     i_go, i_*_lim        sweep start and loop trip counts
//     o_start, i_finish    per-group request/completion handshake
//     o_idxA/B/C           packed {h,w,r,s,k} tuples, h in MSBs
//     o_lane_vld           bit0=A, bit1=B, bit2=C
//     o_busy, o_done       sweep status
interface conv_index_gen_if #(
    parameter int H_LEN = 3,
    parameter int W_LEN = 3,
    parameter int R_LEN = 3,
    parameter int S_LEN = 3,
    parameter int K_LEN = 3
);
    localparam int IDX_W = H_LEN + W_LEN + R_LEN + S_LEN + K_LEN;

    logic             i_go;
    logic [H_LEN-1:0] i_h_lim;
    logic [W_LEN-1:0] i_w_lim;
    logic [R_LEN-1:0] i_r_lim;
    logic [S_LEN-1:0] i_s_lim;
    logic [K_LEN-1:0] i_k_lim;
    logic             o_start;
    logic             i_finish;
    logic [IDX_W-1:0] o_idxA;
    logic [IDX_W-1:0] o_idxB;
    logic [IDX_W-1:0] o_idxC;
    logic [2:0]       o_lane_vld;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_go, i_h_lim, i_w_lim, i_r_lim, i_s_lim, i_k_lim, i_finish,
        output o_start, o_idxA, o_idxB, o_idxC, o_lane_vld, o_busy, o_done
    );

    modport slave (
        output i_go, i_h_lim, i_w_lim, i_r_lim, i_s_lim, i_k_lim, i_finish,
        input  o_start, o_idxA, o_idxB, o_idxC, o_lane_vld, o_busy, o_done
    );
endinterface

// File: rtl/conv_index_gen.sv
// conv_index_gen
//   Sweeps the (k, h, w, r, s) loop nest over latched trip counts, issuing
//   three consecutive index tuples per group and waiting for the address
//   stage to finish each group before advancing.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      conv_index_gen_if.master (go/limits in, tuples/status out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for i_go; limits/cursor/rem loaded on go
//   ISSUE | o_start high for one cycle; lane tuples valid
//   WAIT  | tuples held until i_finish; then advance cursor by 3
//   DONE  | one-cycle o_done pulse, back to IDLE
module conv_index_gen #(
    parameter int H_LEN = 3,
    parameter int W_LEN = 3,
    parameter int R_LEN = 3,
    parameter int S_LEN = 3,
    parameter int K_LEN = 3,
    parameter int CNT_W = 15
) (
    input logic                i_clk,
    input logic                i_rst_n,
    conv_index_gen_if.master   bus
);
    localparam int IDX_W = H_LEN + W_LEN + R_LEN + S_LEN + K_LEN;

    // Field order gives the packed {h,w,r,s,k} layout directly.
    typedef struct packed {
        logic [H_LEN-1:0] h;
        logic [W_LEN-1:0] w;
        logic [R_LEN-1:0] r;
        logic [S_LEN-1:0] s;
        logic [K_LEN-1:0] k;
    } tuple_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t           state_q, state_d;
    tuple_t           cur_q, cur_d;
    tuple_t           lim_q, lim_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    tuple_t           lim_in, idx_b, idx_c;
    logic [2:0]       vld;

    // Odometer step: s innermost, k outermost; each digit wraps at lim-1.
    function automatic tuple_t odo_inc(tuple_t t, tuple_t lim);
        tuple_t n;
        n = t;
        if (t.s != lim.s - S_LEN'(1)) n.s = t.s + S_LEN'(1);
        else begin
            n.s = '0;
            if (t.r != lim.r - R_LEN'(1)) n.r = t.r + R_LEN'(1);
            else begin
                n.r = '0;
                if (t.w != lim.w - W_LEN'(1)) n.w = t.w + W_LEN'(1);
                else begin
                    n.w = '0;
                    if (t.h != lim.h - H_LEN'(1)) n.h = t.h + H_LEN'(1);
                    else begin
                        n.h = '0;
                        if (t.k != lim.k - K_LEN'(1)) n.k = t.k + K_LEN'(1);
                        else n.k = '0;
                    end
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        lim_in = {bus.i_h_lim, bus.i_w_lim, bus.i_r_lim, bus.i_s_lim, bus.i_k_lim};
        idx_b  = odo_inc(cur_q, lim_q);
        idx_c  = odo_inc(idx_b, lim_q);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        lim_d   = lim_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_go) begin
                    lim_d = lim_in;
                    cur_d = '0;
                    rem_d = CNT_W'(bus.i_h_lim) * CNT_W'(bus.i_w_lim) *
                            CNT_W'(bus.i_r_lim) * CNT_W'(bus.i_s_lim) *
                            CNT_W'(bus.i_k_lim);
                    if ((bus.i_h_lim == '0) || (bus.i_w_lim == '0) ||
                        (bus.i_r_lim == '0) || (bus.i_s_lim == '0) ||
                        (bus.i_k_lim == '0))
                        state_d = ST_DONE;
                    else
                        state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_finish) begin
                    rem_d   = (rem_q > CNT_W'(3)) ? rem_q - CNT_W'(3) : '0;
                    cur_d   = odo_inc(idx_c, lim_q);
                    state_d = (rem_d != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            lim_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            lim_q   <= lim_d;
            rem_q   <= rem_d;
        end
    end

    // Lane validity follows the remaining count, so IDLE/DONE (rem==0) and
    // reset naturally blank every lane.
    always_comb begin
        if (rem_q >= CNT_W'(3))      vld = 3'b111;
        else if (rem_q == CNT_W'(2)) vld = 3'b011;
        else if (rem_q == CNT_W'(1)) vld = 3'b001;
        else                         vld = 3'b000;
    end

    assign bus.o_lane_vld = vld;
    assign bus.o_idxA     = vld[0] ? IDX_W'(cur_q) : '0;
    assign bus.o_idxB     = vld[1] ? IDX_W'(idx_b) : '0;
    assign bus.o_idxC     = vld[2] ? IDX_W'(idx_c) : '0;
    assign bus.o_start    = (state_q == ST_ISSUE);
    assign bus.o_busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.o_done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_conv_index_gen.sv
module tb_conv_index_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_index_gen_if bus ();
    conv_index_gen dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  vld;
        logic [14:0] a;
        logic [14:0] b;
        logic [14:0] c;
    } grp_t;

    typedef struct {
        int         h, w, r, s, k;
        int         dly;
        bit         glitch;
        int         exp_groups;
        logic [2:0] exp_last_vld;
    } vec_t;

    grp_t sbq[$];
    vec_t vecs[8];

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] pack(int h, int w, int r, int s, int k);
        return 15'((h << 12) | (w << 9) | (r << 6) | (s << 3) | k);
    endfunction

    // Reference sweep built from plain nested loops, grouped into threes.
    task automatic push_model(int hl, int wl, int rl, int sl, int kl);
        logic [14:0] lst[$];
        for (int k = 0; k < kl; k++)
            for (int h = 0; h < hl; h++)
                for (int w = 0; w < wl; w++)
                    for (int r = 0; r < rl; r++)
                        for (int s = 0; s < sl; s++)
                            lst.push_back(pack(h, w, r, s, k));
        for (int i = 0; i < lst.size(); i += 3) begin
            grp_t g;
            g.vld = 3'b001; g.a = lst[i]; g.b = '0; g.c = '0;
            if (i + 1 < lst.size()) begin g.vld = 3'b011; g.b = lst[i+1]; end
            if (i + 2 < lst.size()) begin g.vld = 3'b111; g.c = lst[i+2]; end
            sbq.push_back(g);
        end
    endtask

    task automatic chk_hold(grp_t e);
        chk("hold_idxA", int'(bus.o_idxA), int'(e.a));
        chk("hold_idxB", int'(bus.o_idxB), int'(e.b));
        chk("hold_idxC", int'(bus.o_idxC), int'(e.c));
        chk("hold_vld", int'(bus.o_lane_vld), int'(e.vld));
        chk("no_restart", int'(bus.o_start), 0);
        chk("wait_busy", int'(bus.o_busy), 1);
    endtask

    task automatic run_vec(int vi, vec_t v);
        int         starts = 0;
        int         budget = 3000;
        int         last_start = 0;
        int         go_cyc;
        logic [2:0] last_vld = 3'b000;
        grp_t       e;
        @(posedge clk); #1;
        bus.i_h_lim = 3'(v.h); bus.i_w_lim = 3'(v.w); bus.i_r_lim = 3'(v.r);
        bus.i_s_lim = 3'(v.s); bus.i_k_lim = 3'(v.k);
        bus.i_go = 1'b1;
        go_cyc = cyc;
        push_model(v.h, v.w, v.r, v.s, v.k);
        @(posedge clk); #1;
        bus.i_go = 1'b0;
        while (!bus.o_done && budget > 0) begin
            budget--;
            if (bus.o_start) begin
                starts++;
                last_start = cyc;
                e = '{3'b000, 15'd0, 15'd0, 15'd0};
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL vec%0d extra_group: got start %0d expected none", vi, starts);
                end else e = sbq.pop_front();
                chk("issue_idxA", int'(bus.o_idxA), int'(e.a));
                chk("issue_idxB", int'(bus.o_idxB), int'(e.b));
                chk("issue_idxC", int'(bus.o_idxC), int'(e.c));
                chk("issue_vld", int'(bus.o_lane_vld), int'(e.vld));
                last_vld = bus.o_lane_vld;
                if (v.glitch) bus.i_finish = 1'b1;
                @(posedge clk); #1;
                bus.i_finish = 1'b0;
                if (v.glitch) begin
                    bus.i_go = 1'b1;
                    bus.i_h_lim = 3'd1; bus.i_w_lim = 3'd1; bus.i_r_lim = 3'd1;
                    bus.i_s_lim = 3'd1; bus.i_k_lim = 3'd1;
                end
                for (int j = 0; j < v.dly; j++) begin
                    chk_hold(e);
                    @(posedge clk); #1;
                    bus.i_go = 1'b0;
                end
                chk_hold(e);
                bus.i_go = 1'b0;
                bus.i_finish = 1'b1;
                @(posedge clk); #1;
                bus.i_finish = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (budget <= 0) begin
            n_vec++; n_err++;
            $display("FAIL vec%0d timeout: got no o_done expected o_done within budget", vi);
        end
        chk("start_count", starts, v.exp_groups);
        chk("last_vld", int'(last_vld), int'(v.exp_last_vld));
        chk("sb_left", sbq.size(), 0);
        sbq.delete();
        if (v.exp_groups > 0) chk("done_latency", cyc - last_start, v.dly + 2);
        else                  chk("zero_done_latency", cyc - go_cyc, 1);
        chk("done_busy", int'(bus.o_busy), 0);
        chk("done_vld", int'(bus.o_lane_vld), 0);
        @(posedge clk); #1;
        chk("done_pulse", int'(bus.o_done), 0);
        chk("idle_busy", int'(bus.o_busy), 0);
        chk("idle_start", int'(bus.o_start), 0);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_start"}, int'(bus.o_start), 0);
        chk({nm, "_busy"}, int'(bus.o_busy), 0);
        chk({nm, "_done"}, int'(bus.o_done), 0);
        chk({nm, "_vld"}, int'(bus.o_lane_vld), 0);
        chk({nm, "_idxA"}, int'(bus.o_idxA), 0);
        chk({nm, "_idxB"}, int'(bus.o_idxB), 0);
        chk({nm, "_idxC"}, int'(bus.o_idxC), 0);
    endtask

    initial begin
        bus.i_go = 1'b0; bus.i_finish = 1'b0;
        bus.i_h_lim = '0; bus.i_w_lim = '0; bus.i_r_lim = '0;
        bus.i_s_lim = '0; bus.i_k_lim = '0;

        //           h  w  r  s  k  dly glitch groups last_vld
        vecs[0] = '{1, 1, 1, 1, 1, 0, 1'b0, 1,  3'b001};
        vecs[1] = '{1, 1, 1, 2, 2, 0, 1'b0, 2,  3'b001};
        vecs[2] = '{1, 1, 0, 1, 1, 0, 1'b0, 0,  3'b000};
        vecs[3] = '{2, 2, 2, 2, 2, 5, 1'b0, 11, 3'b011};
        vecs[4] = '{3, 2, 1, 3, 2, 1, 1'b1, 12, 3'b111};
        vecs[5] = '{7, 1, 2, 3, 1, 0, 1'b0, 14, 3'b111};
        vecs[6] = '{5, 5, 1, 1, 1, 2, 1'b0, 9,  3'b001};
        vecs[7] = '{2, 2, 2, 2, 2, 0, 1'b1, 11, 3'b011};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Abort in WAIT of the second group, then restart from index 0.
        @(posedge clk); #1;
        bus.i_h_lim = 3'd2; bus.i_w_lim = 3'd2; bus.i_r_lim = 3'd2;
        bus.i_s_lim = 3'd2; bus.i_k_lim = 3'd2;
        bus.i_go = 1'b1;
        @(posedge clk); #1;
        bus.i_go = 1'b0;
        chk("rst_g1_start", int'(bus.o_start), 1);
        chk("rst_g1_idxA", int'(bus.o_idxA), 0);
        @(posedge clk); #1;
        bus.i_finish = 1'b1;
        @(posedge clk); #1;
        bus.i_finish = 1'b0;
        chk("rst_g2_start", int'(bus.o_start), 1);
        @(posedge clk); #1;
        chk("rst_g2_wait_busy", int'(bus.o_busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("held_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", int'(bus.o_done), 0);

        bus.i_h_lim = 3'd1; bus.i_w_lim = 3'd1; bus.i_r_lim = 3'd1;
        bus.i_s_lim = 3'd2; bus.i_k_lim = 3'd2;
        bus.i_go = 1'b1;
        @(posedge clk); #1;
        bus.i_go = 1'b0;
        chk("re_g1_start", int'(bus.o_start), 1);
        chk("re_g1_vld", int'(bus.o_lane_vld), 7);
        chk("re_g1_idxA", int'(bus.o_idxA), 0);
        chk("re_g1_idxB", int'(bus.o_idxB), 8);
        chk("re_g1_idxC", int'(bus.o_idxC), 1);
        @(posedge clk); #1;
        bus.i_finish = 1'b1;
        @(posedge clk); #1;
        bus.i_finish = 1'b0;
        chk("re_g2_start", int'(bus.o_start), 1);
        chk("re_g2_vld", int'(bus.o_lane_vld), 1);
        chk("re_g2_idxA", int'(bus.o_idxA), 9);
        chk("re_g2_idxB", int'(bus.o_idxB), 0);
        chk("re_g2_idxC", int'(bus.o_idxC), 0);
        @(posedge clk); #1;
        bus.i_finish = 1'b1;
        @(posedge clk); #1;
        bus.i_finish = 1'b0;
        chk("re_done", int'(bus.o_done), 1);
        @(posedge clk); #1;
        chk("re_done_clear", int'(bus.o_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
